// File: rtl/opcode_frame_gen.sv
// Serialises one payload word per frame onto a 4-bit nibble stream,
// prefixed by a fixed 4-nibble header, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a payload word, din_rdy high
// HEAD  | sending header nibbles 0..3
// DATA  | sending payload nibbles, most significant first
module opcode_frame_gen #(
   parameter logic [15:0] HEADER   = 16'h55D5,
   parameter int          PAY_NIBS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*PAY_NIBS-1:0] din,
   input  logic                  din_vld,
   output logic                  din_rdy,
   output logic [3:0]            dout,
   output logic                  dout_vld,
   input  logic                  dout_rdy,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int W       = 4*PAY_NIBS;
   localparam int CNT_MAX = (PAY_NIBS > 4) ? PAY_NIBS : 4;
   localparam int CW      = $clog2(CNT_MAX);

   localparam logic [CW-1:0] HEAD_LAST = CW'(3);
   localparam logic [CW-1:0] DATA_LAST = CW'(PAY_NIBS-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    sr;
   logic [W-1:0]    sr_shl;
   logic            xfer;
   logic [1:0]      hdr_idx;

   function automatic logic [3:0] hdr_nib(input logic [1:0] idx);
      logic [3:0] nib;
      case (idx)
         2'd0:    nib = HEADER[15:12];
         2'd1:    nib = HEADER[11:8];
         2'd2:    nib = HEADER[7:4];
         default: nib = HEADER[3:0];
      endcase
      return nib;
   endfunction

   assign xfer    = dout_vld && dout_rdy;
   assign sr_shl  = sr << 4;
   assign hdr_idx = cnt[1:0] + 2'd1;
   assign din_rdy = (state == IDLE) && !rst;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dout       <= 4'h0;
         dout_vld   <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= '0;
         sr         <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (din_vld) begin
                  sr       <= din;
                  dout     <= HEADER[15:12];
                  dout_vld <= 1'b1;
                  cnt      <= '0;
                  state    <= HEAD;
               end
            end
            HEAD: begin
               if (xfer) begin
                  if (cnt == HEAD_LAST) begin
                     cnt   <= '0;
                     dout  <= sr[W-1 -: 4];
                     state <= DATA;
                  end else begin
                     cnt  <= cnt + CW'(1);
                     dout <= hdr_nib(hdr_idx);
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  // last nibble: dout keeps its value while dout_vld drops
                  if (cnt == DATA_LAST) begin
                     cnt        <= '0;
                     dout_vld   <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     cnt  <= cnt + CW'(1);
                     sr   <= sr_shl;
                     dout <= sr_shl[W-1 -: 4];
                  end
               end
            end
            default: begin
               state    <= IDLE;
               dout_vld <= 1'b0;
               cnt      <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_opcode_frame_gen.sv
// Randomised and directed bench for opcode_frame_gen: a nibble-queue model
// per instance predicts every output each cycle.
module tb_opcode_frame_gen;

   localparam logic [15:0] H0 = 16'h55D5;
   localparam int          P0 = 4;
   localparam logic [15:0] H1 = 16'hAA55;
   localparam int          P1 = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din0;
   logic        din_vld0, din_rdy0, dout_vld0, dout_rdy0, busy0, frame_done0;
   logic [3:0]  dout0;
   logic [7:0]  din1;
   logic        din_vld1, din_rdy1, dout_vld1, dout_rdy1, busy1, frame_done1;
   logic [3:0]  dout1;

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en   = 1'b0;

   logic [3:0] q0[$];
   logic [3:0] q1[$];
   logic [3:0] hold0, hold1;
   bit         done_exp0, done_exp1;

   always #5 clk = ~clk;

   opcode_frame_gen u_dut0 (
      .clk(clk), .rst(rst),
      .din(din0), .din_vld(din_vld0), .din_rdy(din_rdy0),
      .dout(dout0), .dout_vld(dout_vld0), .dout_rdy(dout_rdy0),
      .busy(busy0), .frame_done(frame_done0)
   );

   opcode_frame_gen #(.HEADER(H1), .PAY_NIBS(P1)) u_dut1 (
      .clk(clk), .rst(rst),
      .din(din1), .din_vld(din_vld1), .din_rdy(din_rdy1),
      .dout(dout1), .dout_vld(dout_vld1), .dout_rdy(dout_rdy1),
      .busy(busy1), .frame_done(frame_done1)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Observe at negedge, then advance the model across the coming posedge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("vld0",  16'(dout_vld0),   16'(q0.size() != 0));
         check("busy0", 16'(busy0),       16'(q0.size() != 0));
         check("rdy0",  16'(din_rdy0),    16'(q0.size() == 0 && !rst));
         check("done0", 16'(frame_done0), 16'(done_exp0));
         if (dout_vld0) check("dout0", 16'(dout0), 16'(q0[0]));
         else           check("hold0", 16'(dout0), 16'(hold0));
         done_exp0 = 1'b0;
         if (rst) begin
            q0.delete();
            hold0 = 4'h0;
         end else if (q0.size() != 0 && dout_rdy0) begin
            hold0 = q0.pop_front();
            if (q0.size() == 0) done_exp0 = 1'b1;
         end else if (q0.size() == 0 && din_vld0) begin
            for (int i = 3; i >= 0; i--) q0.push_back(H0[4*i +: 4]);
            for (int i = P0-1; i >= 0; i--) q0.push_back(din0[4*i +: 4]);
            hold0 = H0[15:12];
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("vld1",  16'(dout_vld1),   16'(q1.size() != 0));
         check("busy1", 16'(busy1),       16'(q1.size() != 0));
         check("rdy1",  16'(din_rdy1),    16'(q1.size() == 0 && !rst));
         check("done1", 16'(frame_done1), 16'(done_exp1));
         if (dout_vld1) check("dout1", 16'(dout1), 16'(q1[0]));
         else           check("hold1", 16'(dout1), 16'(hold1));
         done_exp1 = 1'b0;
         if (rst) begin
            q1.delete();
            hold1 = 4'h0;
         end else if (q1.size() != 0 && dout_rdy1) begin
            hold1 = q1.pop_front();
            if (q1.size() == 0) done_exp1 = 1'b1;
         end else if (q1.size() == 0 && din_vld1) begin
            for (int i = 3; i >= 0; i--) q1.push_back(H1[4*i +: 4]);
            for (int i = P1-1; i >= 0; i--) q1.push_back(din1[4*i +: 4]);
            hold1 = H1[15:12];
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [15:0] d);
      din0     = d;
      din_vld0 = 1'b1;
      cyc();
      din_vld0 = 1'b0;
   endtask

   initial begin
      bit got;
      rst = 1'b1;
      din0 = '0; din_vld0 = 1'b0; dout_rdy0 = 1'b1;
      din1 = '0; din_vld1 = 1'b0; dout_rdy1 = 1'b1;
      hold0 = 4'h0; hold1 = 4'h0; done_exp0 = 1'b0; done_exp1 = 1'b0;
      cyc(); cyc();
      mon_en = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();

      // single frame with dout_rdy high
      send0(16'h1234);
      repeat (12) cyc();

      // back-pressure on every other cycle
      din0 = 16'h1234; din_vld0 = 1'b1;
      for (int i = 0; i < 24; i++) begin
         dout_rdy0 = i[0];
         cyc();
         din_vld0 = 1'b0;
      end
      dout_rdy0 = 1'b1;
      repeat (4) cyc();

      // din_vld held through a busy frame, next word waits for din_rdy
      din0 = 16'hABCD; din_vld0 = 1'b1;
      cyc();
      din0 = 16'h9876;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         if (din_rdy0) got = 1'b1;
         cyc();
      end
      check("rdy_timeout", 16'(got), 16'd1);
      din_vld0 = 1'b0;
      repeat (12) cyc();

      // reset during the second payload nibble
      send0(16'h1234);
      repeat (5) cyc();
      check("mid_vld_pre", 16'(dout_vld0), 16'd1);
      check("mid_dout_pre", 16'(dout0), 16'h2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      send0(16'h0F0F);
      repeat (12) cyc();

      // loopback pattern and the narrow-payload instance
      send0(16'hC3A5);
      din1 = 8'h7E; din_vld1 = 1'b1;
      cyc();
      din_vld1 = 1'b0;
      repeat (12) cyc();

      // randomised traffic on both instances
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 59) == 0);
         din0      = 16'($urandom);
         din_vld0  = ($urandom_range(0, 2) != 0);
         dout_rdy0 = ($urandom_range(0, 3) != 0);
         din1      = 8'($urandom);
         din_vld1  = ($urandom_range(0, 2) != 0);
         dout_rdy1 = ($urandom_range(0, 3) != 0);
         cyc();
      end
      rst = 1'b0; din_vld0 = 1'b0; din_vld1 = 1'b0;
      dout_rdy0 = 1'b1; dout_rdy1 = 1'b1;
      repeat (20) cyc();
      check("drain0", 16'(busy0), 16'd0);
      check("drain1", 16'(busy1), 16'd0);
      @(negedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/opcode_frame_gen.md
Name: opcode_frame_gen

Overview:
- Transmit-side counterpart of the nibble-stream opcode detector.
- Accepts one payload word per frame and serialises it onto a 4-bit nibble stream.
- Each frame is a fixed 4-nibble header (default 5,5,D,5) followed by PAY_NIBS payload nibbles, most significant first.
- Sits between the command/packet source and the nibble-wide link (UART/serial adapter), with valid/ready flow control on both sides.

Parameters:
- HEADER, 16'h55D5: header nibbles, sent HEADER[15:12] first.
- PAY_NIBS, 4: payload nibbles per frame. Legal range 1..15. din width = 4*PAY_NIBS.

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 4*PAY_NIBS: payload word. Nibble [4*PAY_NIBS-1 -: 4] is sent first.
- din_vld, input, 1: payload word valid.
- din_rdy, output, 1: block can accept a word. A word is accepted when din_vld && din_rdy.
- dout, output, 4: current nibble.
- dout_vld, output, 1: dout is valid.
- dout_rdy, input, 1: downstream accepts the nibble. A nibble is transferred when dout_vld && dout_rdy.
- busy, output, 1: frame in progress (state != IDLE).
- frame_done, output, 1: one-cycle pulse on the cycle after the last payload nibble transfers.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, dout=4'h0, dout_vld=0, frame_done=0, nibble counter=0, payload shift register=0.
  - din_rdy is low while rst is high.
- Output registering: all outputs are registered except din_rdy and busy. din_rdy = (state==IDLE) && !rst.
- States:
  - IDLE:
    - On accept: latch din into the shift register, load dout=HEADER[15:12], set dout_vld=1, counter=0, go to HEAD.
    - Latency: first nibble is valid on the cycle after acceptance.
  - HEAD:
    - On each transfer, counter increments and dout loads the next header nibble.
    - On the transfer of header nibble 3: dout loads the shift-register MS nibble, counter=0, go to DATA.
  - DATA:
    - On each transfer, the shift register shifts left by 4 and dout loads the next MS nibble.
    - On the transfer with counter==PAY_NIBS-1: go to IDLE, dout_vld=0, frame_done=1 for one cycle. dout holds the last value.
- Back-pressure: while dout_vld && !dout_rdy, dout and dout_vld hold stable. The counter and shift register do not move. There is no timeout.
- Ready at reset: dout_rdy is ignored when dout_vld=0.
- Input while busy: din_vld outside IDLE is ignored (din_rdy=0). The latched payload is never overwritten mid-frame.
- Throughput: din_rdy rises the cycle after the last transfer. Minimum frame period = 4+PAY_NIBS+1 cycles with dout_rdy held at 1.
- Reset mid-frame: aborts the frame immediately. The next cycle shows dout_vld=0, busy=0, and no frame_done pulse. The partial frame is not resumed.
- Counter: $clog2 sized for max(4,PAY_NIBS). Never exceeds its terminal value. Wrap is by explicit reload, not by overflow.
- Illegal state encodings fall to IDLE with dout_vld=0.

Test Plan:
- Single frame, dout_rdy=1 always; din=16'h1234 accepted in cycle 0:
  - dout_vld high in cycles 1..8 with dout = 5,5,D,5,1,2,3,4.
  - frame_done=1 in cycle 9 only.
  - din_rdy=1 again in cycle 9.
- Back-pressure:
  - Same frame with dout_rdy low on every other cycle → dout holds each nibble until transferred.
  - The sequence is unchanged: 16 active cycles, one frame_done.
- Busy input:
  - din=16'hABCD with din_vld held high through the frame, followed by din=16'h9876.
  - Response: first frame carries A,B,C,D. 16'h9876 is not taken until din_rdy returns, then a second frame sends 5,5,D,5,9,8,7,6.
- Reset mid-frame:
  - Assert rst during the second payload nibble → next cycle dout_vld=0, busy=0, no frame_done.
  - A subsequent din=16'h0F0F produces a complete, correct frame.
- Loopback:
  - Connect dout/dout_vld (dout_rdy=1) to the opcode detector's din/din_vld and send 16'hC3A5.
  - Detector emits a dout_vld pulse with byte 8'hC3, then a dout_vld pulse with byte 8'hA5.
- Parameter check: PAY_NIBS=2, HEADER=16'hAA55, din=8'h7E → stream A,A,5,5,7,E, then frame_done.
